// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch-side initiator for a single-port, read-latency-1
// instruction BRAM. Holds the PC, drives the BRAM word address, buffers
// returned words with their PCs in a small FIFO, and hands them to decode
// over a valid/ready handshake. Supports redirect (branch/jump) with flush.
// Optional build macro: IFU_MISALIGN_TRAP_EN adds a sticky misalign_err
// output that traps misaligned redirect targets instead of masking them.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic             issue_block;
  logic [CNT_W-1:0] occ;
  logic [31:0]      redirect_target;

  assign imem_addr = pc[ADDR_W+1:2];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign occ       = count + CNT_W'(inflight);

`ifdef IFU_MISALIGN_TRAP_EN
  // While trapped, nothing is fetched; the target is loaded exactly as given.
  assign issue_block     = misalign_err;
  assign redirect_target = redirect_pc;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign issue_block     = 1'b0;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
`endif

  // An issue is allowed only when the returning word is guaranteed a FIFO slot.
  assign issue = !rst && !redirect_valid && !issue_block &&
                 ((occ < DEPTH_C) || ((occ == DEPTH_C) && pop));

  assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : 32'h0;

  // PC, in-flight tracking and FIFO bookkeeping; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_err <= |redirect_pc[1:0];
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage: the word returned for last cycle's issue lands at the tail.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed, table-driven bench for instr_fetch_unit.
// Each table row first checks the outputs seen in the current cycle, then
// drives the inputs that the next rising edge will sample. A behavioural
// read-latency-1 BRAM holds mem[i] = 32'h1000_0000 + i.
module tb_instr_fetch_unit;

  typedef struct {
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        chk_addr;
    logic [9:0]  exp_addr;
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  logic [31:0] mem [1024];
  vec_t        vecs [$];
  int          numCompared;
  int          numMismatched;

  instr_fetch_unit #(
    .ADDR_W  (10),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef IFU_MISALIGN_TRAP_EN
    .misalign_err  (misalign_err),
`endif
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural BRAM: word for the sampled address is available next cycle.
  always @(posedge clk) begin
    imem_rdata <= mem[imem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ca, input logic [9:0] ea,
                        input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
    vec_t v;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
    v.chk_addr = ca; v.exp_addr = ea;
    v.rst = r; v.redir = rd; v.redir_pc = rp; v.ready = rdy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    checkOutput($sformatf("v%0d.valid", idx), {31'h0, out_valid}, {31'h0, v.exp_valid});
    if (v.exp_valid) begin
      checkOutput($sformatf("v%0d.instr", idx), out_instr, v.exp_instr);
      checkOutput($sformatf("v%0d.pc", idx), out_pc, v.exp_pc);
    end
    if (v.chk_addr)
      checkOutput($sformatf("v%0d.addr", idx), {22'h0, imem_addr}, {22'h0, v.exp_addr});
    rst            = v.rst;
    redirect_valid = v.redir;
    redirect_pc    = v.redir_pc;
    out_ready      = v.ready;
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rp; out_ready = rdy;
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    imem_rdata     = 32'h0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    checkOutput("reset.instr", out_instr, 32'h0);
    checkOutput("reset.pc", out_pc, 32'h0);
    checkOutput("reset.addr", {22'h0, imem_addr}, 32'h0);
`ifdef IFU_MISALIGN_TRAP_EN
    checkOutput("reset.err", {31'h0, misalign_err}, 32'h0);
`endif

    // Reset release and streaming
    addVec(0, 0, 0, 1, 10'd0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0001, 32'h4, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0002, 32'h8, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0003, 32'hC, 0, 0, 1, 0, 0, 1);
    // Back-pressure after re-reset
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 1, 10'd2, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 1, 10'd2, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 0);
    addVec(1, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0001, 32'h4, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0002, 32'h8, 0, 0, 0, 0, 0, 1);
    // Redirect to 0x40 with a fetch in flight
    addVec(1, 32'h1000_0003, 32'hC, 0, 0, 0, 1, 32'h40, 0);
    addVec(0, 0, 0, 1, 10'd16, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0010, 32'h40, 0, 0, 0, 0, 0, 1);
    // Redirect coincident with a pop
    addVec(1, 32'h1000_0011, 32'h44, 0, 0, 0, 1, 32'h80, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0020, 32'h80, 0, 0, 0, 0, 0, 1);
    // Wrap across the top of the BRAM
    addVec(1, 32'h1000_0021, 32'h84, 0, 0, 0, 1, 32'hFFC, 1);
    addVec(0, 0, 0, 1, 10'd1023, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 10'd0, 0, 0, 0, 1);
    addVec(1, 32'h1000_03FF, 32'hFFC, 0, 0, 0, 0, 0, 1);
    // Back-to-back redirects: last wins
    addVec(1, 32'h1000_0000, 32'h1000, 0, 0, 0, 1, 32'h200, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 32'h40, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0010, 32'h40, 0, 0, 0, 0, 0, 1);
    addVec(1, 32'h1000_0011, 32'h44, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned redirect traps, aligned redirect recovers
    drive(0, 1, 32'h42, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("trap.err", {31'h0, misalign_err}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("trap.valid%0d", k), {31'h0, out_valid}, 32'h0);
      drive(0, 0, 32'h0, 1);
    end
    checkOutput("trap.err_sticky", {31'h0, misalign_err}, 32'h1);
    rst = 0; redirect_valid = 1; redirect_pc = 32'h80;
    drive(0, 0, 32'h0, 1);
    checkOutput("trap.err_clear", {31'h0, misalign_err}, 32'h0);
    drive(0, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("trap.rec_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("trap.rec_instr", out_instr, 32'h1000_0020);
    checkOutput("trap.rec_pc", out_pc, 32'h80);
`else
    // Misaligned redirect target is masked to the word boundary
    drive(0, 1, 32'h43, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("mask.valid0", {31'h0, out_valid}, 32'h0);
    drive(0, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("mask.valid", {31'h0, out_valid}, 32'h1);
    checkOutput("mask.instr", out_instr, 32'h1000_0010);
    checkOutput("mask.pc", out_pc, 32'h40);
`endif

    // Reset overrides a simultaneous redirect
    drive(1, 1, 32'h40, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("rstovr.valid0", {31'h0, out_valid}, 32'h0);
    drive(0, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1);
    checkOutput("rstovr.instr", out_instr, 32'h1000_0000);
    checkOutput("rstovr.pc", out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the single-port instruction BRAM (word-addressed, read latency of 1 clock, no read enable).
- Holds the PC and drives the word address to the BRAM.
- Captures returned words into a small FIFO, together with their PCs.
- Presents instructions to decode over a valid/ready handshake; supports PC redirect (branch/jump) with flush.

Parameters:
- ADDR_W, 10: BRAM word-address width; byte PC bits [ADDR_W+1:2] form the address.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  BRAM word address, equal to pc[ADDR_W+1:2].
- imem_rdata  in  32  BRAM read data; valid the cycle after an address is sampled.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  32  redirect target (byte address).
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction word.
- out_pc  out  32  byte PC of head instruction.

Behaviour:
- Reset: pc=RESET_PC, FIFO count=0, inflight=0, out_valid=0, out_instr=0, out_pc=0. rst overrides redirect_valid.
- pop = out_valid & out_ready. occ = count + inflight.
- issue = !rst & !redirect_valid & (occ < DEPTH | (occ == DEPTH & pop)).
- On issue at an edge:
  - BRAM samples imem_addr.
  - inflight<=1, inflight_pc<=pc, pc<=pc+4 (32-bit, wraps 0xFFFF_FFFC->0).
- With no issue: pc holds and inflight<=0. imem_addr stays stable but the BRAM read is ignored.
- Return: in the cycle after an issue (inflight=1), imem_rdata and inflight_pc are written to the FIFO tail at the edge.
- Push and pop in the same cycle are legal; count is unchanged.
- The issue rule guarantees a push never overflows the FIFO.
- Latency: address issued at edge N, word pushed at edge N+1, out_valid=1 in the cycle after edge N+1 (2 cycles issue-to-visible).
- Throughput: 1 instr/cycle sustained while out_ready=1.
- Back-pressure (out_ready=0):
  - Issuing stops once occ=DEPTH.
  - The head is held stable: out_valid, out_instr and out_pc do not change until popped.
- Redirect (redirect_valid=1 at an edge):
  - FIFO count<=0 and inflight<=0; the in-flight word is discarded.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - No issue that cycle.
  - A pop in the same cycle completes: decode owns that instruction.
  - out_valid=0 the next cycle. The first target instruction appears 3 cycles after the redirect edge (issue at next edge, then 2-cycle latency).
- Back-to-back redirects: the last one wins; each flushes.
- The PC wraps within BRAM naturally: bits above ADDR_W+1 are ignored for imem_addr but kept in out_pc.
- Reset asserted mid-operation clears the FIFO and inflight at that edge regardless of handshake.

Optional Feature:
- IFU_MISALIGN_TRAP_EN defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky), loads pc unmodified, and blocks issue until an aligned redirect or reset clears it.
- Undefined: no misalign_err port; low bits are silently masked to 0.

Test Plan:
- Reset release, RESET_PC=0, mem[0..3]=A0,A1,A2,A3, out_ready=1 -> out_valid first high 2 cycles after rst falls; outputs A0/0x0, A1/0x4, A2/0x8, A3/0xC on consecutive cycles.
- Stream with out_ready low for 5 cycles after the first valid -> head stays A0/0x0; no more than DEPTH words buffered; after release the sequence continues A1, A2 with no gaps or duplicates.
- Redirect to 0x40 while a fetch is in flight (mem[16]=B0) -> no stale word from the old path appears; B0/0x40 visible 3 cycles after the redirect edge, then 0x44.
- Redirect coincident with pop of A1 -> A1 is consumed once; the next out_valid is the target instruction.
- PC at 0xFFC (ADDR_W=10) streaming -> imem_addr wraps 1023->0; out_pc reads 0xFFC then 0x1000.
- Macro defined, redirect_pc=0x42 -> misalign_err=1 and out_valid stays 0; a later redirect to 0x80 clears the error, and mem[32] appears at 0x80.
